// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline inter-stage registers.
// Contents:
//   skid_state_e   - occupancy state of a skid-buffered stage (EMPTY/BUSY/FULL)
//   *_CTRL_W/_W    - per-stage control/data bundle widths
//   occupancy_of() - entry count held in a given state
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

   localparam int IF_ID_CTRL_W   = 4;
   localparam int IF_ID_DATA_W   = 96;
   localparam int ID_EXE_CTRL_W  = 16;
   localparam int ID_EXE_DATA_W  = 160;
   localparam int EXE_MEM_CTRL_W = 8;
   localparam int EXE_MEM_DATA_W = 104;
   localparam int MEM_WB_CTRL_W  = 4;
   localparam int MEM_WB_DATA_W  = 72;

   function automatic logic [1:0] occupancy_of(input skid_state_e s);
      case (s)
         ST_BUSY: return 2'd1;
         ST_FULL: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter without a synchronous clear; only reset zeroes it.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous reset, active-low
//   en    - count enable; ignored once the counter is all-ones
//   cnt   - current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_cnt;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + ONE;
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// up_ready is decoded from the state register only, so no combinational ready path
// crosses the stage. Control bits are zeroed in any bubble; data bits are kept.
// Ports:
//   clk, rst_n            - clock (rising), asynchronous active-low reset
//   flush_i               - synchronous flush, kills every held entry
//   up_valid/up_ready     - upstream handshake
//   up_ctrl/up_data       - upstream payload
//   dn_valid/dn_ready     - downstream handshake
//   dn_ctrl/dn_data       - head entry payload (dn_ctrl = 0 when empty)
//   occupancy             - entries held (0..2)
//   stall_cnt             - saturating count of cycles with dn_valid & ~dn_ready
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W   = 16,
   parameter int DATA_W   = 160,
   parameter int CLR_DATA = 0,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [CTRL_W-1:0] up_ctrl,
   input  logic [DATA_W-1:0] up_data,
   output logic              dn_valid,
   input  logic              dn_ready,
   output logic [CTRL_W-1:0] dn_ctrl,
   output logic [DATA_W-1:0] dn_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   skid_state_e       r_state;
   skid_state_e       w_state_nxt;
   logic [CTRL_W-1:0] r_head_ctrl;
   logic [DATA_W-1:0] r_head_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [DATA_W-1:0] r_skid_data;

   logic w_up_fire;
   logic w_dn_fire;
   logic w_head_ld_up;
   logic w_head_ld_skid;
   logic w_head_clr;
   logic w_skid_ld;
   logic w_skid_clr;

   assign up_ready  = (r_state != ST_FULL);
   assign dn_valid  = (r_state != ST_EMPTY);
   assign w_up_fire = up_valid & up_ready;
   assign w_dn_fire = dn_valid & dn_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; flush wins over any handshake in the same cycle.
   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      if (flush_i) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_up_fire) w_state_nxt = ST_BUSY;
            ST_BUSY: begin
               if (w_up_fire && !w_dn_fire)      w_state_nxt = ST_FULL;
               else if (!w_up_fire && w_dn_fire) w_state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (w_dn_fire) w_state_nxt = ST_BUSY;
            default:  w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Payload load/clear strobes decoded from the current state and handshakes.
   always_comb begin
      w_head_ld_up   = 1'b0;
      w_head_ld_skid = 1'b0;
      w_head_clr     = 1'b0;
      w_skid_ld      = 1'b0;
      w_skid_clr     = 1'b0;
      if (!flush_i) begin
         case (r_state)
            ST_EMPTY: w_head_ld_up = w_up_fire;
            ST_BUSY: begin
               w_head_ld_up = w_up_fire & w_dn_fire;
               w_skid_ld    = w_up_fire & ~w_dn_fire;
               w_head_clr   = ~w_up_fire & w_dn_fire;
            end
            ST_FULL: begin
               w_head_ld_skid = w_dn_fire;
               w_skid_clr     = w_dn_fire;
            end
            default: ;
         endcase
      end
   end

   // NOTE: payload registers are reset so a bubble after reset presents ctrl = 0 and a defined data field.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head_ctrl <= '0;
         r_head_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
      end else if (flush_i) begin
         r_head_ctrl <= '0;
         r_skid_ctrl <= '0;
         if (CLR_DATA != 0) begin
            r_head_data <= '0;
            r_skid_data <= '0;
         end
      end else begin
         if (w_head_ld_up) begin
            r_head_ctrl <= up_ctrl;
            r_head_data <= up_data;
         end else if (w_head_ld_skid) begin
            r_head_ctrl <= r_skid_ctrl;
            r_head_data <= r_skid_data;
         end else if (w_head_clr) begin
            r_head_ctrl <= '0;
         end
         if (w_skid_ld) begin
            r_skid_ctrl <= up_ctrl;
            r_skid_data <= up_data;
         end else if (w_skid_clr) begin
            r_skid_ctrl <= '0;
         end
      end
   end

   // Head ctrl is already cleared when the stage empties; the gate makes the bubble rule explicit.
   assign dn_ctrl   = dn_valid ? r_head_ctrl : '0;
   assign dn_data   = r_head_data;
   assign occupancy = occupancy_of(r_state);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (dn_valid & ~dn_ready),
      .cnt   (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. Two instances share all inputs:
//   dut_a: CLR_DATA = 0, CNT_W = 16
//   dut_b: CLR_DATA = 1, CNT_W = 4
// A queue-based model predicts every output; directed phases pin it with literals,
// then a randomized phase streams traffic with back-pressure and flushes.
module tb_pipe_stage_skid;

   localparam int CW = 16;
   localparam int DW = 160;

   typedef struct {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } entry_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush_i;
   logic          up_valid;
   logic [CW-1:0] up_ctrl;
   logic [DW-1:0] up_data;
   logic          dn_ready;

   logic          a_up_ready, a_dn_valid, b_up_ready, b_dn_valid;
   logic [CW-1:0] a_dn_ctrl, b_dn_ctrl;
   logic [DW-1:0] a_dn_data, b_dn_data;
   logic [1:0]    a_occ, b_occ;
   logic [15:0]   a_stall;
   logic [3:0]    b_stall;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .up_valid(up_valid), .up_ready(a_up_ready), .up_ctrl(up_ctrl), .up_data(up_data),
      .dn_valid(a_dn_valid), .dn_ready(dn_ready), .dn_ctrl(a_dn_ctrl), .dn_data(a_dn_data),
      .occupancy(a_occ), .stall_cnt(a_stall)
   );

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLR_DATA(1), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .up_valid(up_valid), .up_ready(b_up_ready), .up_ctrl(up_ctrl), .up_data(up_data),
      .dn_valid(b_dn_valid), .dn_ready(dn_ready), .dn_ctrl(b_dn_ctrl), .dn_data(b_dn_data),
      .occupancy(b_occ), .stall_cnt(b_stall)
   );

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- behavioural model ----------------
   entry_t        q[$];
   logic [DW-1:0] m_last_a, m_last_b;   // data shown on dn_data when nothing newer is at the head
   int            m_stall_a, m_stall_b;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_last_a  = '0;
         m_last_b  = '0;
         m_stall_a = 0;
         m_stall_b = 0;
      end else begin
         automatic bit v   = (q.size() > 0);
         automatic bit upf = up_valid && (q.size() < 2);
         automatic bit dnf = v && dn_ready;
         if (v && !dn_ready) begin
            if (m_stall_a < 65535) m_stall_a++;
            if (m_stall_b < 15)    m_stall_b++;
         end
         if (flush_i) begin
            q.delete();
            m_last_b = '0;
         end else begin
            if (dnf) void'(q.pop_front());
            if (upf) q.push_back('{c: up_ctrl, d: up_data});
            if (q.size() > 0) begin
               m_last_a = q[0].d;
               m_last_b = q[0].d;
            end
         end
      end
   end

   // Compare process: outputs checked against the model mid-cycle, every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         automatic int            n  = q.size();
         automatic logic [CW-1:0] ec = (n > 0) ? q[0].c : '0;
         check("a_dn_valid", a_dn_valid, n > 0);
         check("a_up_ready", a_up_ready, n < 2);
         check("a_occ", a_occ, n);
         check("a_dn_ctrl", a_dn_ctrl, ec);
         check("a_dn_data", a_dn_data, m_last_a);
         check("a_stall", a_stall, m_stall_a);
         check("b_dn_valid", b_dn_valid, n > 0);
         check("b_up_ready", b_up_ready, n < 2);
         check("b_occ", b_occ, n);
         check("b_dn_ctrl", b_dn_ctrl, ec);
         check("b_dn_data", b_dn_data, m_last_b);
         check("b_stall", b_stall, m_stall_b);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [DW-1:0] d_data;

   initial begin
      rst_n    = 1'b0;
      flush_i  = 1'b0;
      up_valid = 1'b1;
      up_ctrl  = 16'h0005;
      up_data  = rnd_data();
      dn_ready = 1'b1;

      // Reset held with an offer present.
      repeat (3) step();
      check("rst_dn_valid", a_dn_valid, 1'b0);
      check("rst_dn_ctrl", a_dn_ctrl, 16'h0);
      check("rst_up_ready", a_up_ready, 1'b1);
      check("rst_occ", a_occ, 2'd0);
      check("rst_stall", a_stall, 16'd0);
      check("rst_b_data", b_dn_data, 160'd0);
      up_valid = 1'b0;
      rst_n    = 1'b1;
      step();

      // Streaming: 1..8 back-to-back with 1-cycle latency.
      for (int k = 1; k <= 8; k++) begin
         up_valid = 1'b1;
         up_ctrl  = CW'(k);
         up_data  = rnd_data();
         step();
         check("stream_ctrl", a_dn_ctrl, CW'(k));
         check("stream_ready", a_up_ready, 1'b1);
      end
      up_valid = 1'b0;
      step();
      check("stream_drained", a_dn_valid, 1'b0);

      // Back-pressure: A, B accepted, C held upstream.
      dn_ready = 1'b0;
      up_valid = 1'b1;
      up_ctrl = 16'h000A; up_data = rnd_data(); step();
      up_ctrl = 16'h000B; up_data = rnd_data(); step();
      up_ctrl = 16'h000C; up_data = rnd_data(); step();
      check("bp_occ", a_occ, 2'd2);
      check("bp_up_ready", a_up_ready, 1'b0);
      check("bp_head", a_dn_ctrl, 16'h000A);
      check("bp_stall2", a_stall, 16'd2);
      repeat (2) step();
      check("bp_stall4", a_stall, 16'd4);
      dn_ready = 1'b1;
      step();
      check("bp_out_b", a_dn_ctrl, 16'h000B);
      step();
      check("bp_out_c", a_dn_ctrl, 16'h000C);
      up_valid = 1'b0;
      step();
      check("bp_empty", a_dn_valid, 1'b0);
      check("bp_stall_final", a_stall, 16'd4);

      // Flush while FULL, with an offer in the flush cycle.
      dn_ready = 1'b0;
      up_valid = 1'b1;
      d_data   = rnd_data();
      up_ctrl = 16'h0011; up_data = d_data;     step();
      up_ctrl = 16'h0022; up_data = rnd_data(); step();
      check("fl_full", a_occ, 2'd2);
      flush_i = 1'b1;
      up_ctrl = 16'h0033; up_data = rnd_data();
      step();
      check("fl_dn_valid", a_dn_valid, 1'b0);
      check("fl_dn_ctrl_a", a_dn_ctrl, 16'h0);
      check("fl_dn_ctrl_b", b_dn_ctrl, 16'h0);
      check("fl_occ", a_occ, 2'd0);
      check("fl_data_kept", a_dn_data, d_data);
      check("fl_data_zero", b_dn_data, 160'd0);
      check("fl_stall", a_stall, 16'd6);
      flush_i  = 1'b0;
      up_valid = 1'b0;
      dn_ready = 1'b1;
      step();
      check("fl_offer_dropped", a_dn_valid, 1'b0);

      // Saturation of the 4-bit counter, then async reset mid-operation.
      up_valid = 1'b1;
      up_ctrl  = 16'h0044;
      up_data  = rnd_data();
      dn_ready = 1'b0;
      step();
      up_valid = 1'b0;
      repeat (20) step();
      check("sat_b", b_stall, 4'd15);
      check("sat_a", a_stall, 16'd26);
      repeat (3) step();
      check("sat_b_hold", b_stall, 4'd15);
      up_valid = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_stall_a", a_stall, 16'd0);
      check("arst_stall_b", b_stall, 4'd0);
      check("arst_dn_valid", a_dn_valid, 1'b0);
      check("arst_occ", a_occ, 2'd0);
      check("arst_up_ready", a_up_ready, 1'b1);
      step();
      up_valid = 1'b0;
      dn_ready = 1'b1;
      rst_n    = 1'b1;
      step();

      // Randomized traffic with back-pressure and occasional flush.
      for (int i = 0; i < 3000; i++) begin
         up_valid = ($urandom_range(0, 99) < 65);
         up_ctrl  = CW'($urandom);
         up_data  = rnd_data();
         dn_ready = ($urandom_range(0, 99) < 60);
         flush_i  = ($urandom_range(0, 99) < 4);
         step();
      end
      flush_i  = 1'b0;
      up_valid = 1'b0;
      dn_ready = 1'b1;
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
